test_engine_nic_output_scheduler: RTL and testbench
===================================================

// Module: test_engine_nic_output_scheduler
// PURPOSE
//  - Output-side control for a multi-source NIC. Up to NUM_CH processing nodes share one
//    router injection port.
//  - Latches per-channel done strobes and arbitrates round-robin among them.
//  - Owns router credit flow control and drives the flit selector that picks which
//    output register is exposed to the router, one packet at a time.
// PARAMETERS
//  NUM_CH         4   number of source channels (1..8)
//  FLITS_PER_PKT  5   flits per packet (1..15)
//  CREDITS        4   router buffer slots (packets) available after reset (>=1)
//  (derived) SEL_W = clog2(FLITS_PER_PKT+1); CRT_W = clog2(CREDITS+1); PTR_W = max(1,clog2(NUM_CH))
// PORTS
//  clk                   in   1       clock; all state updates on posedge
//  reset                 in   1       synchronous, active-high
//  credit_in_din         in   1       one-cycle pulse: router freed one packet slot
//  done_strobe_din       in   NUM_CH  one-cycle pulse per channel: result ready to send
//  zero_credits_dout     out  1       credit count == 0
//  credit_count_dout     out  CRT_W   current credit count
//  grant_dout            out  NUM_CH  one-hot channel being served; 0 when IDLE
//  output_selector_dout  out  SEL_W   flit select; 0 outside ACTIVE
//  busy_dout             out  1       state != IDLE
//  credit_error_dout     out  1       sticky credit overflow flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset values:
//    state=IDLE, credits=CREDITS, pending=0, rr pointer=0 (ch0 highest priority),
//    grant=0, selector=0, busy=0, zero_credits=0, credit_error=0.
//  - Pending latch: pending[i] is set on the edge after done_strobe_din[i].
//    A strobe on an already-pending channel merges (no count).
//    pending[i] clears at the IDLE->REQUEST edge that grants i. A strobe for i in that
//    same cycle keeps pending[i]=1 (new request).
//  - Arbiter: in IDLE with any pending bit, the winner is the first pending channel at or
//    after the rr pointer, modulo NUM_CH. The winner is latched into grant; the pointer
//    becomes winner+1 (wraps to 0).
//  - FSM:
//    IDLE    -> REQUEST  when |pending (registered; a strobe alone does not advance IDLE).
//    REQUEST -> ACTIVE   when credits != 0, else hold with grant stable. Flit counter
//               loads FLITS_PER_PKT on entry to ACTIVE.
//    ACTIVE  -> IDLE     after the cycle in which selector == 1. The counter decrements
//               once per ACTIVE cycle.
//  - Selector: ACTIVE lasts exactly FLITS_PER_PKT cycles; the selector shows
//    FLITS_PER_PKT, FLITS_PER_PKT-1, ..., 1. No stall input: once ACTIVE, the packet
//    always completes.
//  - Latency: strobe in cycle 0, credits available ->
//    pending at 1, REQUEST at 2, ACTIVE at 3, IDLE at 3+FLITS_PER_PKT.
//    Minimum gap between consecutive packets is 2 cycles (IDLE, REQUEST).
//  - Credits:
//    - Decrement on the REQUEST->ACTIVE edge; increment on credit_in_din.
//    - Both in the same cycle -> unchanged.
//    - credit_in_din at CREDITS (no decrement that cycle) -> saturate, count unchanged.
//    - Decrement is never issued at 0 (FSM holds in REQUEST).
//  - zero_credits_dout and credit_count_dout are combinational from the credit register.
//  - Reset mid-packet aborts immediately. All state returns to reset values; pending
//    requests are discarded.
// CONFIGURATION
//  - NIC_OUT_CREDIT_CHECK_EN defined:
//    - credit_error_dout sets on any credit_in_din that would exceed CREDITS.
//    - It stays 1 until reset.
//  - NIC_OUT_CREDIT_CHECK_EN undefined:
//    - credit_error_dout is tied 0.
//    - Overflow still saturates silently.
// TESTING
//  1. Reset, strobe ch2 once, no credit_in ->
//     grant=4'b0100 at cycle 2; selector 5,4,3,2,1 in cycles 3..7; credits 4->3; IDLE at 8.
//  2. Strobe ch0,ch1,ch3 same cycle ->
//     served in order 0,1,3; a later ch0 strobe after ch3's grant is served next (rr wrap).
//  3. Send 4 packets with no credit_in ->
//     zero_credits=1; 5th request holds in REQUEST, grant stable, selector 0.
//     One credit_in pulse -> ACTIVE on the following edge.
//  4. credit_in on the same cycle as the REQUEST->ACTIVE edge ->
//     count unchanged (e.g. 2 stays 2).
//  5. With CREDITS=4 and no packet sent, pulse credit_in ->
//     count stays 4; credit_error=1 with NIC_OUT_CREDIT_CHECK_EN, else 0.
//  6. Assert reset while selector==3 ->
//     next cycle all outputs at reset values; pending requests lost; credits=4.

Source files
------------

// File: rtl/test_engine_nic_output_scheduler.sv
// test_engine_nic_output_scheduler: round-robin packet scheduler with router credit flow control; define NIC_OUT_CREDIT_CHECK_EN for a sticky credit overflow flag
module test_engine_nic_output_scheduler #(
  parameter int NUM_CH = 4,
  parameter int FLITS_PER_PKT = 5,
  parameter int CREDITS = 4,
  localparam int SEL_W = $clog2(FLITS_PER_PKT + 1),
  localparam int CRT_W = $clog2(CREDITS + 1),
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              credit_in_din,
  input  logic [NUM_CH-1:0] done_strobe_din,
  output logic              zero_credits_dout,
  output logic [CRT_W-1:0]  credit_count_dout,
  output logic [NUM_CH-1:0] grant_dout,
  output logic [SEL_W-1:0]  output_selector_dout,
  output logic              busy_dout,
  output logic              credit_error_dout
);
  localparam logic [1:0] IDLE = 2'd0, REQUEST = 2'd1, ACTIVE = 2'd2;
  logic [1:0] state;
  logic [CRT_W-1:0] credits;
  logic [NUM_CH-1:0] pending, grant, win_oh;
  logic [PTR_W-1:0] ptr, win;
  logic [SEL_W-1:0] cnt;
  logic found, take, dec, at_max;
  // first pending channel at or after the round-robin pointer
  always_comb begin
    win = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && pending[(int'(ptr) + k) % NUM_CH]) begin
        win = PTR_W'((int'(ptr) + k) % NUM_CH);
        found = 1'b1;
      end
    end
  end
  assign win_oh = NUM_CH'(1) << win;
  assign take = state == IDLE && |pending;
  assign dec = state == REQUEST && credits != '0;
  assign at_max = credits == CRT_W'(CREDITS);
  // pending latch, credit counter and packet FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      credits <= CRT_W'(CREDITS);
      pending <= '0;
      ptr <= '0;
      grant <= '0;
      cnt <= '0;
    end else begin
      pending <= (pending & ~(take ? win_oh : '0)) | done_strobe_din;
      credits <= (credit_in_din && !dec && !at_max) ? credits + 1'b1 :
                 (dec && !credit_in_din) ? credits - 1'b1 : credits;
      if (take) begin
        state <= REQUEST;
        grant <= win_oh;
        ptr <= (int'(win) == NUM_CH - 1) ? '0 : win + 1'b1;
      end
      if (dec) begin
        state <= ACTIVE;
        cnt <= SEL_W'(FLITS_PER_PKT);
      end
      if (state == ACTIVE) begin
        cnt <= cnt - 1'b1;
        if (cnt == SEL_W'(1)) begin
          state <= IDLE;
          grant <= '0;
        end
      end
    end
  end
  assign grant_dout = grant;
  assign output_selector_dout = (state == ACTIVE) ? cnt : '0;
  assign busy_dout = state != IDLE;
  assign zero_credits_dout = credits == '0;
  assign credit_count_dout = credits;
`ifdef NIC_OUT_CREDIT_CHECK_EN
  logic err;
  // sticky flag for a credit return beyond the router buffer size
  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else if (credit_in_din && !dec && at_max) err <= 1'b1;
  end
  assign credit_error_dout = err;
`else
  assign credit_error_dout = 1'b0;
`endif
endmodule

// File: tb/tb_test_engine_nic_output_scheduler.sv
// tb_test_engine_nic_output_scheduler: directed bench with a flit scoreboard for the output scheduler
module tb_test_engine_nic_output_scheduler;
  logic clk = 1'b0, reset = 1'b1, credit_in_din = 1'b0;
  logic [3:0] done_strobe_din = '0;
  logic zero_credits_dout, busy_dout, credit_error_dout;
  logic [2:0] credit_count_dout, output_selector_dout;
  logic [3:0] grant_dout;
  logic [6:0] q[$];
  logic [6:0] exp_flit;
  int passed = 0, total = 0;
  logic exp_err;

  test_engine_nic_output_scheduler dut (
    .clk(clk), .reset(reset), .credit_in_din(credit_in_din), .done_strobe_din(done_strobe_din),
    .zero_credits_dout(zero_credits_dout), .credit_count_dout(credit_count_dout),
    .grant_dout(grant_dout), .output_selector_dout(output_selector_dout),
    .busy_dout(busy_dout), .credit_error_dout(credit_error_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_pkt(input logic [3:0] g, input int last);
    for (int s = 5; s >= last; s--) q.push_back({g, 3'(s)});
  endtask

  task automatic do_reset;
    reset = 1'b1;
    credit_in_din = 1'b0;
    done_strobe_din = '0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic strobe(input logic [3:0] m);
    done_strobe_din = m;
    tick;
    done_strobe_din = '0;
  endtask

  task automatic wait_idle;
    int n = 0;
    while ((busy_dout || q.size() != 0) && n < 300) begin
      tick;
      n++;
    end
    chk("idle_timeout", {31'b0, busy_dout || q.size() != 0}, 0);
  endtask

  // every exposed flit must match the next scoreboard entry
  always @(negedge clk) begin
    if (output_selector_dout != 3'd0) begin
      exp_flit = (q.size() != 0) ? q.pop_front() : 7'bx;
      chk("flit", {25'b0, grant_dout, output_selector_dout}, {25'b0, exp_flit});
    end
  end

  initial begin
`ifdef NIC_OUT_CREDIT_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    // single packet from ch2
    do_reset;
    chk("rst_grant", grant_dout, 0);
    chk("rst_sel", output_selector_dout, 0);
    chk("rst_busy", busy_dout, 0);
    chk("rst_zero", zero_credits_dout, 0);
    chk("rst_credits", credit_count_dout, 4);
    chk("rst_err", credit_error_dout, 0);
    push_pkt(4'b0100, 1);
    strobe(4'b0100);
    chk("t1_c1_busy", busy_dout, 0);
    tick;
    chk("t1_c2_grant", grant_dout, 4'b0100);
    chk("t1_c2_sel", output_selector_dout, 0);
    tick;
    chk("t1_c3_sel", output_selector_dout, 5);
    chk("t1_c3_credits", credit_count_dout, 3);
    for (int i = 0; i < 4; i++) tick;
    chk("t1_c7_sel", output_selector_dout, 1);
    tick;
    chk("t1_c8_busy", busy_dout, 0);
    chk("t1_c8_grant", grant_dout, 0);
    // ch0,ch1,ch3 together, then ch0 again after ch3's grant
    do_reset;
    push_pkt(4'b0001, 1);
    push_pkt(4'b0010, 1);
    push_pkt(4'b1000, 1);
    strobe(4'b1011);
    for (int n = 0; n < 100 && grant_dout != 4'b1000; n++) tick;
    chk("t2_ch3_grant", grant_dout, 4'b1000);
    push_pkt(4'b0001, 1);
    strobe(4'b0001);
    wait_idle;
    chk("t2_credits", credit_count_dout, 0);
    chk("t2_zero", zero_credits_dout, 1);
    // out of credits: hold in REQUEST
    push_pkt(4'b0010, 1);
    strobe(4'b0010);
    tick;
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_grant", grant_dout, 4'b0010);
      chk("t3_hold_sel", output_selector_dout, 0);
      chk("t3_hold_busy", busy_dout, 1);
      tick;
    end
    credit_in_din = 1'b1;
    tick;
    credit_in_din = 1'b0;
    chk("t3_credit_back", credit_count_dout, 1);
    chk("t3_still_req", output_selector_dout, 0);
    tick;
    chk("t3_active", output_selector_dout, 5);
    chk("t3_credits0", credit_count_dout, 0);
    wait_idle;
    // round-robin skips ch0 in favour of ch3 when pointer sits at 3
    do_reset;
    push_pkt(4'b0100, 1);
    strobe(4'b0100);
    tick;
    tick;
    push_pkt(4'b1000, 1);
    push_pkt(4'b0001, 1);
    strobe(4'b1001);
    wait_idle;
    chk("t4_pre_credits", credit_count_dout, 1);
    credit_in_din = 1'b1;
    tick;
    credit_in_din = 1'b0;
    chk("t4_two", credit_count_dout, 2);
    // credit return on the REQUEST->ACTIVE edge
    push_pkt(4'b0010, 1);
    strobe(4'b0010);
    tick;
    chk("t4_req_grant", grant_dout, 4'b0010);
    credit_in_din = 1'b1;
    tick;
    credit_in_din = 1'b0;
    chk("t4_active", output_selector_dout, 5);
    chk("t4_unchanged", credit_count_dout, 2);
    wait_idle;
    // overflow at full credits
    do_reset;
    credit_in_din = 1'b1;
    tick;
    credit_in_din = 1'b0;
    chk("t5_credits", credit_count_dout, 4);
    chk("t5_err", credit_error_dout, exp_err);
    tick;
    tick;
    chk("t5_err_sticky", credit_error_dout, exp_err);
    // reset mid-packet
    do_reset;
    push_pkt(4'b0001, 3);
    strobe(4'b0011);
    for (int i = 0; i < 4; i++) tick;
    chk("t6_sel3", output_selector_dout, 3);
    reset = 1'b1;
    tick;
    chk("t6_grant", grant_dout, 0);
    chk("t6_sel", output_selector_dout, 0);
    chk("t6_busy", busy_dout, 0);
    chk("t6_zero", zero_credits_dout, 0);
    chk("t6_credits", credit_count_dout, 4);
    chk("t6_err", credit_error_dout, 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick;
    chk("t6_pending_lost", busy_dout, 0);
    chk("t6_queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
